// File: rtl/rr_packet_stream_arbiter_pkg.sv
// rr_packet_stream_arbiter_pkg: shared FSM encoding and id width helper for the packet stream arbiter
package rr_packet_stream_arbiter_pkg;
  typedef enum logic {ARB_IDLE = 1'b0, ARB_LOCKED = 1'b1} arb_state_e;
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/stream_slice_2entry.sv
// stream_slice_2entry: 2-entry ping-pong register buffer, full throughput with registered ready
module stream_slice_2entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         valid_o,
  output logic [W-1:0] data_o
);
  logic [1:0]   wr_q, rd_q;
  logic [W-1:0] mem_q [2];
  // Occupancy comes only from registered pointers, so a same-cycle pop never admits a push.
  assign full_o  = (wr_q[1] != rd_q[1]) && (wr_q[0] == rd_q[0]);
  assign valid_o = wr_q != rd_q;
  assign data_o  = mem_q[rd_q[0]];
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q     <= '0;
      rd_q     <= '0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      if (push_i && !full_o) begin
        mem_q[wr_q[0]] <= data_i;
        wr_q           <= wr_q + 2'd1;
      end
      if (pop_i && valid_o) rd_q <= rd_q + 2'd1;
    end
  end
endmodule

// File: rtl/rr_packet_stream_arbiter.sv
// rr_packet_stream_arbiter: round-robin packet-granular arbiter of NUM_REQ streams onto one buffered output
module rr_packet_stream_arbiter
  import rr_packet_stream_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = id_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            valid_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_REQ-1:0]            last_in,
  output logic [NUM_REQ-1:0]            ready_out,
  output logic                          valid_out,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          last_out,
  output logic [ID_WIDTH-1:0]           id_out,
  input  logic                          ready_in
);
  arb_state_e          state_q, state_d;
  logic [ID_WIDTH-1:0] rr_q, rr_d, lock_q, lock_d;
  logic [ID_WIDTH-1:0] grant, idx, sel, nxt;
  logic                any, full, accept, sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  // Scan from the farthest candidate back to rr_q so the nearest valid requester wins.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_WIDTH'((int'(rr_q) + k) % NUM_REQ);
      if (valid_in[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end
  assign sel      = (state_q == ARB_LOCKED) ? lock_q : grant;
  assign nxt      = (sel == ID_WIDTH'(NUM_REQ - 1)) ? '0 : sel + ID_WIDTH'(1);
  assign sel_last = last_in[sel];
  assign sel_data = data_in[sel*DATA_WIDTH +: DATA_WIDTH];
  assign accept   = |(valid_in & ready_out);
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      rr_q    <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      lock_q  <= lock_d;
    end
  end
  always_comb begin
    state_d = accept ? (sel_last ? ARB_IDLE : ARB_LOCKED) : state_q;
    rr_d    = (accept && sel_last) ? nxt : rr_q;
    lock_d  = (accept && !sel_last) ? sel : lock_q;
  end
  always_comb begin
    ready_out = (reset || full || (state_q == ARB_IDLE && !any)) ? '0 : NUM_REQ'(1) << sel;
  end
  stream_slice_2entry #(.W(ID_WIDTH + 1 + DATA_WIDTH)) u_slice (
    .clk     (clk),
    .reset   (reset),
    .push_i  (accept),
    .data_i  ({sel, sel_last, sel_data}),
    .pop_i   (valid_out & ready_in),
    .full_o  (full),
    .valid_o (valid_out),
    .data_o  ({id_out, last_out, data_out})
  );
endmodule

// File: tb/tb_rr_packet_stream_arbiter.sv
// tb_rr_packet_stream_arbiter: vector table, corner sequences and queue-model random checking
module tb_rr_packet_stream_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  valid_in, last_in, ready_out;
  logic [31:0] data_in;
  logic        valid_out, last_out, ready_in;
  logic [7:0]  data_out;
  logic [1:0]  id_out;
  logic        reset3, ready3, vo3, lo3;
  logic [2:0]  v3, l3, ro3;
  logic [23:0] d3;
  logic [7:0]  do3;
  logic [1:0]  id3;
  int total = 0;
  int bad = 0;
  logic [10:0] q[$];
  int owner = -1;
  int rr = 0;
  int sel_m = -1;

  always #5 clk = ~clk;

  rr_packet_stream_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in), .last_in(last_in),
    .ready_out(ready_out), .valid_out(valid_out), .data_out(data_out), .last_out(last_out),
    .id_out(id_out), .ready_in(ready_in)
  );

  rr_packet_stream_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8)) dut3 (
    .clk(clk), .reset(reset3), .valid_in(v3), .data_in(d3), .last_in(l3),
    .ready_out(ro3), .valid_out(vo3), .data_out(do3), .last_out(lo3),
    .id_out(id3), .ready_in(ready3)
  );

  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic [3:0] l;
    logic [3:0] er;
    logic       ev;
    logic [1:0] eid;
    logic       el;
    logic       z;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic [3:0] v, logic [3:0] l, logic [3:0] er,
                              logic ev, logic [1:0] eid, logic el, logic z);
    vec_t t;
    t.rst = rst; t.v = v; t.l = l; t.er = er; t.ev = ev; t.eid = eid; t.el = el; t.z = z;
    return t;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", n, a, e, $time);
    end
  endtask

  // Drive one cycle's inputs and compare against the queue model of the buffer and arbiter.
  task automatic drive(input logic rst, input logic [3:0] v, input logic [31:0] d,
                       input logic [3:0] l, input logic ri);
    logic [3:0] er;
    @(negedge clk);
    reset = rst; valid_in = v; data_in = d; last_in = l; ready_in = ri;
    #1;
    sel_m = -1;
    if (!rst && q.size() < 2) begin
      if (owner >= 0) sel_m = owner;
      else for (int k = 0; k < 4; k++) if (sel_m < 0 && v[(rr + k) % 4]) sel_m = (rr + k) % 4;
    end
    er = (sel_m >= 0) ? 4'(1 << sel_m) : 4'd0;
    chk("model_ready", 32'(ready_out), 32'(er));
    chk("model_valid", 32'(valid_out), 32'(q.size() > 0));
    if (q.size() > 0) chk("model_beat", 32'({id_out, last_out, data_out}), 32'(q[0]));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      q.delete();
      owner = -1;
      rr = 0;
    end else begin
      if (q.size() > 0 && ready_in) void'(q.pop_front());
      if (sel_m >= 0 && valid_in[sel_m]) begin
        q.push_back({2'(sel_m), last_in[sel_m], data_in[sel_m*8 +: 8]});
        if (last_in[sel_m]) begin
          owner = -1;
          rr = (sel_m + 1) % 4;
        end else owner = sel_m;
      end
    end
  endtask

  initial begin
    logic [3:0] last_r;
    int acc_n;
    reset = 1'b1; valid_in = '0; last_in = '0; data_in = '0; ready_in = 1'b1;
    reset3 = 1'b1; v3 = '0; l3 = '0; d3 = '0; ready3 = 1'b1;
    repeat (2) @(posedge clk);

    tbl.push_back(mk(1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 1));
    for (int i = 0; i < 10; i++) tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'hF, 4'hF, 4'h1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'hF, 4'hF, 4'h2, 1, 0, 1, 0));
    tbl.push_back(mk(0, 4'hF, 4'hF, 4'h4, 1, 1, 1, 0));
    tbl.push_back(mk(0, 4'hF, 4'hF, 4'h8, 1, 2, 1, 0));
    tbl.push_back(mk(0, 4'hF, 4'hF, 4'h1, 1, 3, 1, 0));
    tbl.push_back(mk(0, 4'hF, 4'hF, 4'h2, 1, 0, 1, 0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'h6, 4'h0, 4'h2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'h6, 4'h0, 4'h2, 1, 1, 0, 0));
    tbl.push_back(mk(0, 4'h6, 4'h2, 4'h2, 1, 1, 0, 0));
    tbl.push_back(mk(0, 4'h6, 4'h4, 4'h4, 1, 1, 1, 0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 1, 2, 1, 0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'h5, 4'h5, 4'h1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'h5, 4'h5, 4'h4, 1, 0, 1, 0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 1, 2, 1, 0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].v, 32'hA3A2A1A0, tbl[i].l, 1'b1);
      chk($sformatf("vec%0d_ready", i), 32'(ready_out), 32'(tbl[i].er));
      chk($sformatf("vec%0d_valid", i), 32'(valid_out), 32'(tbl[i].ev));
      if (tbl[i].ev)
        chk($sformatf("vec%0d_beat", i), 32'({id_out, last_out, data_out}),
            32'({tbl[i].eid, tbl[i].el, 8'hA0 + 8'(tbl[i].eid)}));
      if (tbl[i].z) chk($sformatf("vec%0d_zero", i), 32'({id_out, last_out, data_out}), 32'd0);
      tick();
    end

    acc_n = 0;
    last_r = '1;
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 4'b0001, {24'h0, 8'h10 + 8'(acc_n)}, 4'b0001, 1'b0);
      if (valid_in[0] && ready_out[0]) acc_n++;
      last_r = ready_out;
      tick();
    end
    chk("bp_accepted", 32'(acc_n), 32'd2);
    chk("bp_ready_low", 32'(last_r), 32'd0);
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 4'b0000, 32'h0, 4'b0000, 1'b1);
      if (c < 2) chk("bp_order", 32'({valid_out, id_out, data_out}), 32'({1'b1, 2'd0, 8'h10 + 8'(c)}));
      else chk("bp_drained", 32'(valid_out), 32'd0);
      tick();
    end

    drive(1'b0, 4'b1000, 32'hA3A2A1A0, 4'b0000, 1'b0);
    chk("mid_lock_grant", 32'(ready_out), 32'h8);
    tick();
    drive(1'b1, 4'b1000, 32'hA3A2A1A0, 4'b0000, 1'b0);
    chk("mid_rst_ready", 32'(ready_out), 32'd0);
    tick();
    drive(1'b0, 4'b1001, 32'hA3A2A1A0, 4'b1001, 1'b1);
    chk("mid_rst_valid", 32'(valid_out), 32'd0);
    chk("mid_rst_grant", 32'(ready_out), 32'h1);
    tick();
    drive(1'b0, 4'b0000, 32'h0, 4'b0000, 1'b1);
    chk("mid_rst_id", 32'({valid_out, id_out}), 32'({1'b1, 2'd0}));
    tick();

    for (int c = 0; c < 2500; c++) begin
      drive($urandom_range(0, 199) == 0, 4'($urandom), $urandom, 4'($urandom & $urandom),
            $urandom_range(0, 9) < 7);
      tick();
    end

    @(negedge clk);
    reset3 = 1'b0; v3 = 3'b111; l3 = 3'b111; d3 = 24'hB2B1B0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("nr3_ready", 32'(ro3), 32'(1 << (c % 3)));
      if (c > 0)
        chk("nr3_beat", 32'({vo3, id3, lo3, do3}),
            32'({1'b1, 2'((c - 1) % 3), 1'b1, 8'hB0 + 8'((c - 1) % 3)}));
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
